// File: rtl/game_pkg.sv
// Game-state geometry, pipe-word field positions and palette shared by the game controller and the renderer.
package game_pkg;

    localparam int BIRD_X    = 40;
    localparam int BIRD_W    = 16;
    localparam int BIRD_H    = 16;
    localparam int PIPE_W    = 50;
    localparam int V_ACT     = 480;
    localparam int FLASH_BIT = 3;

    // Pipe word layout: [27:20] gap, [19:10] left x, [9:0] top-edge y
    localparam int GAP_MSB = 27;
    localparam int GAP_LSB = 20;
    localparam int X_MSB   = 19;
    localparam int X_LSB   = 10;
    localparam int Y_MSB   = 9;
    localparam int Y_LSB   = 0;

    // Score bar: 16 squares, MSB leftmost
    localparam int SCORE_Y0    = 4;
    localparam int SCORE_Y1    = 11;
    localparam int SCORE_X0    = 8;
    localparam int SCORE_PITCH = 10;
    localparam int SCORE_SQ    = 8;

    localparam logic [11:0] COL_SCORE_ON  = 12'hFFF;
    localparam logic [11:0] COL_SCORE_OFF = 12'h444;
    localparam logic [11:0] COL_BIRD_UP   = 12'hFF0;
    localparam logic [11:0] COL_BIRD      = 12'hFA0;
    localparam logic [11:0] COL_PIPE      = 12'h2A2;
    localparam logic [11:0] COL_SKY       = 12'h8CF;
    localparam logic [11:0] COL_FLASH     = 12'hF44;

endpackage

// File: rtl/pipe_hit.sv
// Pixel-vs-pipe test: inside the pipe column and outside its vertical gap.
// Combinational, no backpressure; arithmetic widened to 11 bits so nothing wraps.
module pipe_hit
    import game_pkg::*;
(
    input  logic [9:0]  pix_x,
    input  logic [9:0]  gy,
    input  logic [31:0] pipe,
    output logic        hit
);

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] gap;
    logic [10:0] x11;
    logic [10:0] gy11;
    logic        col_hit;
    logic        row_hit;
    logic        unused_bits;

    assign px   = {1'b0, pipe[X_MSB:X_LSB]};
    assign py   = {1'b0, pipe[Y_MSB:Y_LSB]};
    assign gap  = {3'b000, pipe[GAP_MSB:GAP_LSB]};
    assign x11  = {1'b0, pix_x};
    assign gy11 = {1'b0, gy};

    assign col_hit = (x11 >= px) && (x11 < px + 11'(PIPE_W));
    assign row_hit = (gy11 <= py) || (gy11 >= py + gap);
    assign hit     = col_hit && row_hit;

    assign unused_bits = ^pipe[31:28];

endmodule

// File: rtl/game_render.sv
// Classifies each pixel against a once-per-frame snapshot of game state and drives 12-bit RGB.
// Latency 2 clk pix->rgb; no backpressure, one pixel accepted every cycle.
module game_render
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [15:0] score,
    input  logic        fail,
    output logic [11:0] rgb,
    output logic        rgb_valid
);

    logic [15:0] snap_bird_y;
    logic [31:0] snap_pipe1;
    logic [31:0] snap_pipe2;
    logic [31:0] snap_pipe3;
    logic [15:0] snap_score;
    logic        snap_fail;
    logic [7:0]  frame_cnt;

    // Snapshot updates at the edge, so a pixel sharing a cycle with frame_start sees the old frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_bird_y <= '0;
            snap_pipe1  <= '0;
            snap_pipe2  <= '0;
            snap_pipe3  <= '0;
            snap_score  <= '0;
            snap_fail   <= 1'b0;
            frame_cnt   <= '0;
        end else if (frame_start) begin
            snap_bird_y <= bird_y;
            snap_pipe1  <= pipe1;
            snap_pipe2  <= pipe2;
            snap_pipe3  <= pipe3;
            snap_score  <= score;
            snap_fail   <= fail;
            frame_cnt   <= frame_cnt + 8'd1;
        end
    end

    logic [9:0]  gy;
    logic        gy_ok;
    logic [15:0] gy16;
    logic [15:0] by;
    logic        hit_p1, hit_p2, hit_p3;
    logic        bird_hit;
    logic        score_hit;
    logic        score_bit;

    assign gy    = 10'(V_ACT - 1) - pix_y;
    assign gy_ok = pix_y < 10'(V_ACT);
    assign gy16  = {6'd0, gy};
    assign by    = {1'b0, snap_bird_y[14:0]};

    pipe_hit u_pipe1 (.pix_x(pix_x), .gy(gy), .pipe(snap_pipe1), .hit(hit_p1));
    pipe_hit u_pipe2 (.pix_x(pix_x), .gy(gy), .pipe(snap_pipe2), .hit(hit_p2));
    pipe_hit u_pipe3 (.pix_x(pix_x), .gy(gy), .pipe(snap_pipe3), .hit(hit_p3));

    assign bird_hit = gy_ok
                   && (pix_x >= 10'(BIRD_X)) && (pix_x < 10'(BIRD_X + BIRD_W))
                   && (gy16 >= by) && (gy16 < by + 16'(BIRD_H));

    always_comb begin
        score_hit = 1'b0;
        score_bit = 1'b0;
        if (pix_y >= 10'(SCORE_Y0) && pix_y <= 10'(SCORE_Y1)) begin
            for (int i = 0; i < 16; i++) begin
                if (pix_x >= 10'(SCORE_X0 + SCORE_PITCH * i) &&
                    pix_x <= 10'(SCORE_X0 + SCORE_PITCH * i + SCORE_SQ - 1)) begin
                    score_hit = 1'b1;
                    score_bit = snap_score[15 - i];
                end
            end
        end
    end

    logic s1_vld;
    logic s1_score_hit;
    logic s1_score_bit;
    logic s1_bird_hit;
    logic s1_pipe_hit;
    logic s1_bird_up;
    logic s1_flash;

    // Colour selectors travel with the pixel so a snapshot update cannot recolour stage 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld       <= 1'b0;
            s1_score_hit <= 1'b0;
            s1_score_bit <= 1'b0;
            s1_bird_hit  <= 1'b0;
            s1_pipe_hit  <= 1'b0;
            s1_bird_up   <= 1'b0;
            s1_flash     <= 1'b0;
        end else begin
            s1_vld       <= video_on;
            s1_score_hit <= score_hit;
            s1_score_bit <= score_bit;
            s1_bird_hit  <= bird_hit;
            s1_pipe_hit  <= gy_ok && (hit_p1 || hit_p2 || hit_p3);
            s1_bird_up   <= snap_bird_y[15];
            s1_flash     <= snap_fail && frame_cnt[FLASH_BIT];
        end
    end

    logic [11:0] pix_rgb;

    always_comb begin
        pix_rgb = s1_flash ? COL_FLASH : COL_SKY;
        if (s1_score_hit) begin
            pix_rgb = s1_score_bit ? COL_SCORE_ON : COL_SCORE_OFF;
        end else if (s1_bird_hit) begin
            pix_rgb = s1_bird_up ? COL_BIRD_UP : COL_BIRD;
        end else if (s1_pipe_hit) begin
            pix_rgb = COL_PIPE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= s1_vld ? pix_rgb : 12'h000;
            rgb_valid <= s1_vld;
        end
    end

endmodule

// File: tb/tb_game_render.sv
// Scoreboard bench for game_render: directed pixels push expected colour and due cycle; a monitor pops on rgb_valid.
module tb_game_render;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        video_on = 1'b0;
    logic [15:0] bird_y = '0;
    logic [31:0] pipe1 = '0;
    logic [31:0] pipe2 = '0;
    logic [31:0] pipe3 = '0;
    logic [15:0] score = '0;
    logic        fail = 1'b0;
    logic [11:0] rgb;
    logic        rgb_valid;

    game_render dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .bird_y(bird_y), .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3),
        .score(score), .fail(fail), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        int          due;
        string       name;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] fc = 8'd0;

    localparam logic [11:0] SKY   = 12'h8CF;
    localparam logic [11:0] FLASH = 12'hF44;
    localparam logic [11:0] PIPE  = 12'h2A2;
    localparam logic [11:0] BIRD  = 12'hFA0;
    localparam logic [11:0] BIRDU = 12'hFF0;
    localparam logic [11:0] SON   = 12'hFFF;
    localparam logic [11:0] SOFF  = 12'h444;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pw(input int gap, input int x, input int y);
        return {4'h0, 8'(gap), 10'(x), 10'(y)};
    endfunction

    // Inputs are applied just after a falling edge and held for one cycle
    task automatic drive(input string nm, input int x, input int y, input logic vo,
                         input logic fs, input logic [11:0] exp);
        exp_t t;
        pix_x = 10'(x);
        pix_y = 10'(y);
        video_on = vo;
        frame_start = fs;
        if (fs) fc = fc + 8'd1;
        if (vo) begin
            t.rgb = exp;
            t.due = cyc + 2;
            t.name = nm;
            sb.push_back(t);
        end
        @(negedge clk);
        video_on = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pix(input string nm, input int x, input int y, input logic [11:0] exp);
        drive(nm, x, y, 1'b1, 1'b0, exp);
    endtask

    task automatic frame();
        drive("frame", 0, 0, 1'b0, 1'b1, 12'h000);
    endtask

    always @(negedge clk) begin
        if (rst && rgb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(rgb_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_rgb"}, 32'(rgb), 32'(mon_e.rgb));
                chk({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_valid", 32'(rgb_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Zero snapshot: pipes at x 0 fill columns 0..49, bird sits at gy 0..15 above them
        pix("zero_sky", 300, 300, SKY);
        pix("zero_bird", 45, 470, BIRD);

        bird_y = 16'd240;
        pipe1 = pw(0, 640, 0);
        pipe2 = pw(0, 640, 0);
        pipe3 = pw(0, 640, 0);
        score = 16'h0000;
        frame();
        pix("bird", 45, 230, BIRD);
        pix("bird_right", 60, 230, SKY);
        pix("bird_edge", 55, 224, BIRD);
        pix("bird_top", 45, 223, SKY);

        pipe1 = pw(100, 210, 150);
        pipe2 = pw(0, 600, 0);
        frame();
        pix("pipe_upper", 220, 100, PIPE);
        pix("pipe_gap", 220, 300, SKY);
        pix("pipe_top_edge", 220, 329, PIPE);
        pix("pipe_below_gap", 220, 330, PIPE);
        pix("pipe_gap_high", 220, 230, SKY);
        pix("pipe_gap_end", 220, 229, PIPE);
        pix("pipe_x_end", 260, 100, SKY);
        pix("pipe_x_last", 259, 100, PIPE);
        pix("pipe_x_before", 209, 100, SKY);
        pix("pipe2_edge", 639, 200, PIPE);

        score = 16'h8001;
        bird_y = 16'd470;
        frame();
        pix("score_b15", 8, 4, SON);
        pix("score_b14", 18, 4, SOFF);
        pix("score_b0", 158, 11, SON);
        pix("score_b0_end", 165, 4, SON);
        pix("score_gap", 16, 4, SKY);
        pix("score_gap_end", 166, 4, SKY);
        pix("score_left", 7, 4, SKY);
        pix("score_row12", 10, 12, SKY);
        pix("score_over_bird", 42, 4, SOFF);
        pix("bird_in_score_gap", 47, 4, BIRD);

        pipe1 = pw(100, 300, 150);
        pix("midframe_old", 220, 100, PIPE);
        pix("midframe_new", 310, 100, SKY);
        drive("fs_same_cycle", 220, 100, 1'b1, 1'b1, PIPE);
        pix("after_fs_old", 220, 100, SKY);
        pix("after_fs_new", 310, 100, PIPE);

        fail = 1'b1;
        bird_y = 16'h8000 | 16'd240;
        frame();
        pix("fail_bg_f5", 400, 300, SKY);
        pix("bird_rising", 45, 230, BIRDU);
        for (int k = 0; k < 260; k++) begin
            frame();
            pix("flash", 400, 300, fc[3] ? FLASH : SKY);
        end
        fail = 1'b0;
        frame();
        chk("flash_frame_bit", 32'(fc[3]), 32'd1);
        pix("no_fail_bg", 400, 300, SKY);

        drive("video_off", 45, 230, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        chk("video_off_rgb", 32'(rgb), 32'd0);
        chk("video_off_valid", 32'(rgb_valid), 32'd0);

        pix("pre_rst_a", 45, 230, BIRDU);
        pix_x = 10'd400;
        pix_y = 10'd300;
        video_on = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_rst_rgb", 32'(rgb), 32'(BIRDU));
        rst = 1'b0;
        #1;
        chk("async_rst_rgb", 32'(rgb), 32'd0);
        chk("async_rst_valid", 32'(rgb_valid), 32'd0);
        sb.delete();
        video_on = 1'b0;
        fc = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pix("post_rst_bird", 45, 470, BIRD);
        pix("post_rst_sky", 400, 300, SKY);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
